ssp_xfer_arbiter: RTL and testbench

//  Two-requester transfer arbiter/sequencer in front of the SSP APB-side port. Grants the SSP to one

---
 rtl/ssp_xfer_arbiter.sv | 111 +++++++++++
 tb/tb_ssp_xfer_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_xfer_arbiter.sv
// ssp_xfer_arbiter: round-robin two-requester burst sequencer for the SSP APB port, with pre-emptive RX drain
module ssp_xfer_arbiter #(
    parameter int DATA_W   = 8,
    parameter int BURST_W  = 4,
    parameter int RX_DRAIN = 4
) (
    input  logic               PCLK,
    input  logic               CLEAR_B,
    input  logic               req0,
    input  logic               req1,
    input  logic [BURST_W-1:0] len0,
    input  logic [BURST_W-1:0] len1,
    input  logic [DATA_W-1:0]  txd0,
    input  logic [DATA_W-1:0]  txd1,
    output logic               tx_pop0,
    output logic               tx_pop1,
    output logic [1:0]         grant,
    output logic               done,
    output logic               done_id,
    output logic               PSEL,
    output logic               PWRITE,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    input  logic               SSPTXINTR,
    input  logic               SSPRXINTR,
    output logic               rx_valid,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_owner
);
    localparam int CW = RX_DRAIN > 1 ? $clog2(RX_DRAIN) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, FIN} state_t;

    state_t             state, state_n;
    logic               owner, rr, ret_write, win, wr_go, start;
    logic [BURST_W-1:0] remaining, win_len;
    logic [CW-1:0]      drain_cnt;

    always_ff @(posedge PCLK or negedge CLEAR_B)
        if (!CLEAR_B) state <= IDLE;
        else          state <= state_n;

    always_comb begin
        state_n = state;
        PSEL    = 1'b0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        tx_pop0 = 1'b0;
        tx_pop1 = 1'b0;
        wr_go   = 1'b0;
        win     = (req0 && req1) ? rr : req1;
        win_len = win ? len1 : len0;
        start   = state == IDLE && !SSPRXINTR && (req0 || req1);
        case (state)
            IDLE:  state_n = SSPRXINTR ? DRAIN : start ? (win_len != '0 ? WRITE : FIN) : IDLE;
            WRITE: begin
                wr_go   = !SSPRXINTR && !SSPTXINTR;
                PSEL    = wr_go;
                PWRITE  = wr_go;
                PWDATA  = wr_go ? (owner ? txd1 : txd0) : '0;
                tx_pop0 = wr_go && !owner;
                tx_pop1 = wr_go && owner;
                state_n = SSPRXINTR ? DRAIN : (wr_go && remaining == BURST_W'(1)) ? FIN : WRITE;
            end
            DRAIN: begin
                PSEL    = 1'b1;
                state_n = drain_cnt == CW'(RX_DRAIN - 1) ? (ret_write ? WRITE : IDLE) : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge CLEAR_B)
        if (!CLEAR_B) begin
            owner     <= 1'b0;
            rr        <= 1'b0;
            ret_write <= 1'b0;
            remaining <= '0;
            drain_cnt <= '0;
            grant     <= '0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_owner  <= 1'b0;
        end else begin
            done      <= state != FIN && state_n == FIN;
            rx_valid  <= state == DRAIN;
            drain_cnt <= (state == DRAIN && state_n == DRAIN) ? drain_cnt + CW'(1) : '0;
            if (state != FIN && state_n == FIN)
                done_id <= state == IDLE ? win : owner;
            if (state == DRAIN) begin
                rx_data  <= PRDATA;
                rx_owner <= owner;
            end
            if (state != DRAIN && state_n == DRAIN)
                ret_write <= state == WRITE;
            if (start) begin
                owner     <= win;
                remaining <= win_len;
                grant     <= win ? 2'b10 : 2'b01;
            end
            if (wr_go)
                remaining <= remaining - BURST_W'(1);
            // rr flips to the other requester only once a burst actually completes
            if (state == FIN) begin
                grant <= '0;
                rr    <= ~owner;
            end
        end
endmodule

// File: tb/tb_ssp_xfer_arbiter.sv
// tb_ssp_xfer_arbiter: randomized scoreboard bench; stimulus queues expectations, a negedge monitor checks them
module tb_ssp_xfer_arbiter;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int RD = 4;

    logic          PCLK = 1'b0, CLEAR_B = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [BW-1:0] len0 = '0, len1 = '0;
    logic [DW-1:0] txd0 = '0, txd1 = '0, PRDATA = '0;
    logic          SSPTXINTR = 1'b0, SSPRXINTR = 1'b0;
    logic          tx_pop0, tx_pop1, done, done_id, PSEL, PWRITE, rx_valid, rx_owner;
    logic [1:0]    grant;
    logic [DW-1:0] PWDATA, rx_data;

    ssp_xfer_arbiter #(.DATA_W(DW), .BURST_W(BW), .RX_DRAIN(RD)) dut (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .txd0(txd0), .txd1(txd1), .tx_pop0(tx_pop0), .tx_pop1(tx_pop1), .grant(grant),
        .done(done), .done_id(done_id), .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .SSPTXINTR(SSPTXINTR), .SSPRXINTR(SSPRXINTR), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_owner(rx_owner)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {logic id; int len;} burst_t;
    typedef struct {logic id; logic [7:0] d;} rx_t;

    int     errors = 0, checks = 0;
    burst_t exp_done[$];
    logic   exp_grant[$];
    rx_t    exp_rx[$];
    logic [7:0] src0[$], src1[$], ew0[$], ew1[$];
    logic   m_fav = 1'b0, noise = 1'b0;
    int     bl0 = 0, bl1 = 0;
    int     cyc = 0, n_wr = 0, n_rd = 0, burst_wr = 0, last_wr = 0;
    logic   pop_seen0 = 1'b0, pop_seen1 = 1'b0, done_seen = 1'b0, done_id_seen = 1'b0, prev_done = 1'b0;
    logic [1:0] prev_grant = '0;
    burst_t m_b;
    rx_t    m_r;
    logic [7:0] m_e;
    logic   m_id, m_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // monitor / scoreboard
    always @(negedge PCLK) begin
        cyc++;
        pop_seen0    = tx_pop0;
        pop_seen1    = tx_pop1;
        done_seen    = done;
        done_id_seen = done_id;
        if (!CLEAR_B) begin
            burst_wr   = 0;
            prev_grant = '0;
            prev_done  = 1'b0;
        end else begin
            if (PSEL && PWRITE) begin
                chk("tx_pop_onehot", 32'(tx_pop0 ^ tx_pop1), 1);
                chk("wr_txintr_clear", 32'(SSPTXINTR), 0);
                m_id = tx_pop1;
                chk("wr_grant", 32'(grant), m_id ? 2 : 1);
                if (m_id ? ew1.size() == 0 : ew0.size() == 0) miss("wr_extra", 32'(PWDATA));
                else begin
                    m_e = m_id ? ew1.pop_front() : ew0.pop_front();
                    chk("wr_data", 32'(PWDATA), 32'(m_e));
                end
                n_wr++;
                burst_wr++;
                last_wr = cyc;
            end else if (PSEL) begin
                chk("rd_bus", 32'({PWDATA, tx_pop1, tx_pop0}), 0);
                n_rd++;
            end else
                chk("idle_bus", 32'({PWRITE, PWDATA, tx_pop1, tx_pop0}), 0);
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (exp_grant.size() == 0) miss("grant_extra", 32'(grant));
                else begin
                    m_g = exp_grant.pop_front();
                    chk("grant", 32'(grant), m_g ? 2 : 1);
                end
            end
            if (prev_done) chk("after_done", 32'({done, grant}), 0);
            if (done) begin
                if (exp_done.size() == 0) miss("done_extra", 32'(done_id));
                else begin
                    m_b = exp_done.pop_front();
                    chk("done_id", 32'(done_id), 32'(m_b.id));
                    chk("burst_len", burst_wr, m_b.len);
                    if (m_b.len > 0) chk("done_latency", cyc - last_wr, 1);
                end
                burst_wr = 0;
            end
            if (rx_valid) begin
                if (exp_rx.size() == 0) miss("rx_extra", 32'(rx_data));
                else begin
                    m_r = exp_rx.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(m_r.d));
                    chk("rx_owner", 32'(rx_owner), 32'(m_r.id));
                end
            end
            prev_grant = grant;
            prev_done  = done;
        end
    end

    // one clock: requester sources advance on pops, requests drop after their last burst
    task automatic step();
        @(posedge PCLK);
        #1;
        if (pop_seen0 && src0.size() != 0) void'(src0.pop_front());
        if (pop_seen1 && src1.size() != 0) void'(src1.pop_front());
        if (done_seen && done_id_seen && bl1 > 0) begin
            bl1--;
            if (bl1 == 0) req1 = 1'b0;
        end
        if (done_seen && !done_id_seen && bl0 > 0) begin
            bl0--;
            if (bl0 == 0) req0 = 1'b0;
        end
        txd0 = src0.size() != 0 ? src0[0] : 8'($urandom);
        txd1 = src1.size() != 0 ? src1[0] : 8'($urandom);
        if (noise) SSPTXINTR = $urandom_range(0, 3) == 0;
    endtask

    task automatic add_byte(input logic id, input logic [7:0] b);
        if (id) begin src1.push_back(b); ew1.push_back(b); end
        else    begin src0.push_back(b); ew0.push_back(b); end
    endtask

    task automatic setup(input logic id, input int len, input int n);
        if (id) begin len1 = BW'(len); bl1 = n; end
        else    begin len0 = BW'(len); bl0 = n; end
    endtask

    // reference arbitration: sole requester wins, contention goes to the favoured one, favour flips to the other
    task automatic plan();
        int c0 = bl0, c1 = bl1;
        logic w;
        burst_t b;
        while (c0 + c1 > 0) begin
            w = (c0 > 0 && c1 > 0) ? m_fav : (c1 > 0);
            b.id  = w;
            b.len = w ? int'(len1) : int'(len0);
            exp_grant.push_back(w);
            exp_done.push_back(b);
            if (w) c1--; else c0--;
            m_fav = !w;
        end
        if (bl0 > 0) req0 = 1'b1;
        if (bl1 > 0) req1 = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_done.size() != 0 || bl0 != 0 || bl1 != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            errors++;
            checks++;
            $display("FAIL timeout: %0d bursts outstanding, required 0", exp_done.size());
        end
        repeat (3) step();
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (n_wr < target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL wait_writes: got %0d writes, required %0d", n_wr, target);
        end
    endtask

    task automatic drain(input logic owner);
        rx_t r;
        SSPRXINTR = 1'b1;
        step();
        SSPRXINTR = 1'b0;
        for (int i = 0; i < RD; i++) begin
            PRDATA = 8'($urandom);
            r.id = owner;
            r.d  = PRDATA;
            exp_rx.push_back(r);
            step();
        end
        PRDATA = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1 [8] = '{8'h94, 8'h0F, 8'h51, 8'h24, 8'h67, 8'hF3, 8'hB6, 8'h84};
        int base, rbase;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'({done, done_id}), 0);
        chk("rst_rx", 32'({rx_valid, rx_data, rx_owner}), 0);
        chk("rst_bus", 32'({PSEL, PWRITE, PWDATA}), 0);
        chk("rst_pop", 32'({tx_pop1, tx_pop0}), 0);
        CLEAR_B = 1'b1;
        step();

        // fixed 8-byte burst from requester 0
        foreach (t1[i]) add_byte(1'b0, t1[i]);
        setup(1'b0, 8, 1);
        plan();
        wait_done();

        // both requesting, two bursts each, alternation
        for (int i = 0; i < 4; i++) add_byte(1'(i & 1), 8'($urandom));
        for (int i = 0; i < 4; i++) add_byte(1'(i & 1), 8'($urandom));
        setup(1'b0, 2, 2);
        setup(1'b1, 2, 2);
        plan();
        wait_done();

        // TX FIFO full for 5 cycles after the 3rd byte
        for (int i = 0; i < 6; i++) add_byte(1'b0, 8'($urandom));
        setup(1'b0, 6, 1);
        base = n_wr;
        plan();
        wait_wr(base + 3);
        SSPTXINTR = 1'b1;
        repeat (5) step();
        chk("stall_writes", n_wr - base, 3);
        SSPTXINTR = 1'b0;
        wait_done();

        // RX drain pre-empts requester 1 after 2 bytes
        for (int i = 0; i < 6; i++) add_byte(1'b1, 8'($urandom));
        setup(1'b1, 6, 1);
        base = n_wr;
        plan();
        wait_wr(base + 2);
        rbase = n_rd;
        drain(1'b1);
        chk("drain_reads", n_rd - rbase, RD);
        wait_done();

        // zero-length burst
        setup(1'b1, 0, 1);
        base = n_wr;
        plan();
        wait_done();
        chk("len0_writes", n_wr - base, 0);

        // drain while idle tags the last owner
        rbase = n_rd;
        drain(1'b1);
        repeat (3) step();
        chk("idle_drain_reads", n_rd - rbase, RD);
        chk("idle_drain_rx_left", exp_rx.size(), 0);

        // async reset mid-burst, then a fresh full burst
        for (int i = 0; i < 8; i++) add_byte(1'b0, 8'($urandom));
        setup(1'b0, 8, 1);
        base = n_wr;
        plan();
        wait_wr(base + 3);
        CLEAR_B = 1'b0;
        #1;
        chk("mid_rst_bus", 32'({PSEL, PWRITE, PWDATA, tx_pop1, tx_pop0}), 0);
        chk("mid_rst_regs", 32'({grant, done, rx_valid}), 0);
        src0.delete();
        ew0.delete();
        exp_done.delete();
        exp_grant.delete();
        m_fav = 1'b0;
        repeat (2) step();
        CLEAR_B = 1'b1;
        for (int i = 0; i < 8; i++) add_byte(1'b0, 8'($urandom));
        setup(1'b0, 8, 1);
        plan();
        wait_done();

        // randomized rounds with TX back-pressure noise
        noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int mask = $urandom_range(1, 3);
            for (int id = 0; id < 2; id++)
                if (mask[id]) begin
                    int len = $urandom_range(0, 15);
                    int n   = $urandom_range(1, 2);
                    for (int k = 0; k < len * n; k++) add_byte(1'(id), 8'($urandom));
                    setup(1'(id), len, n);
                end
            plan();
            wait_done();
        end
        noise = 1'b0;
        SSPTXINTR = 1'b0;
        repeat (3) step();

        chk("queues_empty", exp_done.size() + exp_grant.size() + exp_rx.size() + ew0.size() + ew1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
